// File: rtl/adsr_envelope.sv
// Four-stage ADSR envelope generator. The accumulator steps once per sample_clock
// rising edge and its top bits drive the amplifier volume.
module adsr_envelope #(
  parameter int unsigned ACCBITS  = 16,
  parameter int unsigned VOLBITS  = 8,
  parameter int unsigned RATEBITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_clock,
  input  logic                gate,
  input  logic [RATEBITS-1:0] attack,
  input  logic [RATEBITS-1:0] decay,
  input  logic [RATEBITS-1:0] sustain,
  input  logic [RATEBITS-1:0] rel,
  output logic [VOLBITS-1:0]  volume,
  output logic [2:0]          stage,
  output logic                active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

  localparam int unsigned W = ACCBITS + 1;
  localparam logic [ACCBITS-1:0] ACC_MAX = '1;

  stage_t               state, state_nx;
  logic [ACCBITS-1:0]   acc, acc_nx;
  logic                 sc_q, gate_q;
  logic                 tick, rise;
  logic [ACCBITS-1:0]   target;
  logic [RATEBITS-1:0]  down_rate;
  logic [W-1:0]         add_res, sub_res;

  assign tick      = sample_clock & ~sc_q;
  assign rise      = gate & ~gate_q;
  assign target    = {sustain, {(ACCBITS-RATEBITS){1'b0}}};
  assign down_rate = (state == DECAY) ? decay : rel;
  // Extra top bit carries overflow (add) or borrow (sub) so results clamp instead of wrapping.
  assign add_res   = {1'b0, acc} + W'(attack) + W'(1);
  assign sub_res   = {1'b0, acc} - W'(down_rate) - W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      sc_q   <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      sc_q   <= sample_clock;
      gate_q <= gate;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    if (rise) begin
      state_nx = ATTACK;
    end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nx = RELEASE;
    end else if (tick) begin
      case (state)
        IDLE: acc_nx = '0;
        ATTACK: begin
          if (add_res >= {1'b0, ACC_MAX}) begin
            acc_nx   = ACC_MAX;
            state_nx = DECAY;
          end else begin
            acc_nx = add_res[ACCBITS-1:0];
          end
        end
        DECAY: begin
          if (sub_res[W-1] || sub_res[ACCBITS-1:0] <= target) begin
            acc_nx   = target;
            state_nx = SUSTAIN;
          end else begin
            acc_nx = sub_res[ACCBITS-1:0];
          end
        end
        SUSTAIN: acc_nx = target;
        RELEASE: begin
          if (sub_res[W-1] || sub_res[ACCBITS-1:0] == '0) begin
            acc_nx   = '0;
            state_nx = IDLE;
          end else begin
            acc_nx = sub_res[ACCBITS-1:0];
          end
        end
        default: begin
          acc_nx   = '0;
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign volume = acc[ACCBITS-1 -: VOLBITS];
  assign stage  = state;
  assign active = (state != IDLE);

endmodule
